secuenciador_alu: RTL
=====================

# secuenciador_alu

Sequencer that sits directly upstream and downstream of the 8-bit ALU. It accepts one 13-bit register-to-register instruction over a valid/ready handshake and reads both operands from an internal 8×8-bit register file. It drives the ALU control and operand buses, then writes the ALU result back to the destination register and latches the 3-bit status flags. One instruction is in flight at a time.

## Interface
- ALU_WAIT, 1: cycles the ALU inputs are held stable before writeback; legal range 1–15.

- i_Clk  in  1  sole clock; all state changes on its rising edge.
- i_Reset_n  in  1  reset, synchronous, active-low.
- i_Instr_Valid  in  1  instruction offered.
- o_Instr_Ready  out  1  sequencer can accept an instruction.
- i_Instr  in  13  [12:9] opcode (bit 12 = ALU enable, [11:9] = ALU operation), [8:6] rd, [5:3] rs1, [2:0] rs2.
- i_Wr_En  in  1  external register load strobe.
- i_Wr_Addr  in  3  external load address.
- i_Wr_Data  in  8  external load data.
- i_Rd_Addr  in  3  debug read address.
- o_Rd_Data  out  8  R[i_Rd_Addr], combinational.
- o_Control_ALU  out  4  to the ALU control input.
- o_Operandos  out  16  {R[rs2], R[rs1]}: [7:0] = op1, [15:8] = op2.
- i_Resultado  in  8  ALU result.
- i_Banderas  in  3  ALU flags {Z, N, C}.
- o_Banderas  out  3  flags latched at the last enabled writeback.
- o_Done  out  1  one-cycle pulse when an instruction retires.
- o_Busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, WRITE.
- IDLE:
  - o_Instr_Ready = 1.
  - On i_Instr_Valid & o_Instr_Ready: latch i_Instr and go to ISSUE.
- ISSUE:
  - o_Control_ALU = latched opcode.
  - o_Operandos built from the register file as it is in this cycle.
  - Load the wait counter with ALU_WAIT - 1, then go to WAIT.
- WAIT:
  - Hold o_Control_ALU and o_Operandos.
  - Decrement the counter; when it reaches 0, go to WRITE.
- WRITE:
  - o_Done = 1; o_Control_ALU still holds the opcode.
  - If opcode bit 12 = 1: at this edge, R[rd] <= i_Resultado and o_Banderas <= i_Banderas.
  - If opcode bit 12 = 0 (NOP): no register or flag update, but o_Done still pulses.
  - Next state: IDLE.
- In IDLE, o_Control_ALU = 4'b0000, so the ALU holds its previous result.
- o_Operandos is driven from the latched rs1/rs2 in every state.
- External load: i_Wr_En is honoured only in IDLE and ignored in all other states.
  - A load and an instruction accept in the same cycle are both performed.
  - The instruction sees the new value, because operands are read in ISSUE.
- Read-after-write: a back-to-back instruction sees the previous writeback.
- rd may equal rs1 or rs2; the writeback overwrites the source.
- A new instruction can never be accepted in WRITE.
- Reset (i_Reset_n = 0 at a rising edge) gives:
  - state = IDLE;
  - all registers = 0x00;
  - o_Banderas = 3'b000, o_Done = 0, o_Busy = 0, o_Control_ALU = 0;
  - o_Instr_Ready = 1 in the first cycle after reset is released.
  - An in-flight instruction is dropped and does not retire.

## Timing
- The accept edge is cycle 0.
- ISSUE is cycle 1; WAIT covers cycles 2 .. ALU_WAIT + 1.
- WRITE and the o_Done pulse are in cycle ALU_WAIT + 2; R[rd] is visible on o_Rd_Data in cycle ALU_WAIT + 3.
- o_Instr_Ready is low from cycle 1 through cycle ALU_WAIT + 2.
- Throughput: one instruction per ALU_WAIT + 3 cycles.
- ALU inputs are stable for at least ALU_WAIT + 1 cycles before the result is captured.
- Only the destination register and o_Banderas change at the writeback edge.

## Configuration
- SECALU_R0_CERO_EN defined:
  - R0 is hardwired to 0x00; reads of R0 return 0.
  - Writeback and external loads to R0 are discarded.
  - Flags still update on an enabled writeback to rd = 0.
- Undefined: R0 is an ordinary register.

## Test plan
- Reset, then load R1 = 0x05 and R2 = 0x03; ADD rd = 3 (opcode 4'b1000), ALU_WAIT = 1 -> o_Done in cycle 3, R3 = 0x08, o_Banderas = 3'b000.
- SUB with R1 = 0x03, R2 = 0x03, rd = 4 -> R4 = 0x00, o_Banderas[2] (Z) = 1.
- NOP (opcode 4'b0011) after the ADD -> o_Done pulses, R3 still 0x08, flags unchanged, o_Control_ALU[3] = 0 throughout.
- i_Wr_En to R1 = 0x7F together with an accepted OR rs1 = 1, rs2 = 2 -> operand op1 = 0x7F; i_Wr_En during WAIT is ignored.
- Reset asserted in WAIT with rd = 5 -> no o_Done, R5 = 0x00, o_Instr_Ready = 1 in the first cycle after release.
- With SECALU_R0_CERO_EN, ADD rd = 0 -> R0 reads 0x00 and flags update; without it, R0 = the sum.

Source files
------------

// File: rtl/secuenciador_alu_if.sv
// secuenciador_alu_if
// Groups the instruction handshake and the ALU-facing buses of the
// sequencer. The master side is the upstream instruction source plus the
// ALU itself. The slave side is the sequencer.
interface secuenciador_alu_if;
    logic        i_Instr_Valid;
    logic        o_Instr_Ready;
    logic [12:0] i_Instr;
    logic [3:0]  o_Control_ALU;
    logic [15:0] o_Operandos;
    logic [7:0]  i_Resultado;
    logic [2:0]  i_Banderas;

    modport master (
        output i_Instr_Valid,
        output i_Instr,
        output i_Resultado,
        output i_Banderas,
        input  o_Instr_Ready,
        input  o_Control_ALU,
        input  o_Operandos
    );

    modport slave (
        input  i_Instr_Valid,
        input  i_Instr,
        input  i_Resultado,
        input  i_Banderas,
        output o_Instr_Ready,
        output o_Control_ALU,
        output o_Operandos
    );
endinterface

// File: rtl/secuenciador_alu.sv
// secuenciador_alu
// Single-issue sequencer wrapped around an external 8-bit ALU.
// - Accepts one 13-bit register-to-register instruction per handshake.
// - Reads both operands from an internal 8x8 register file.
// - Holds the ALU inputs for ALU_WAIT cycles.
// - Writes the result back and latches the ALU flags.
// Optional feature, selected by the macro SECALU_R0_CERO_EN:
// - R0 is hardwired to zero.
// - Writes to R0 are discarded, but the flags still update.
module secuenciador_alu #(
    parameter int ALU_WAIT = 1
) (
    input  logic                  i_Clk,
    input  logic                  i_Reset_n,
    secuenciador_alu_if.slave     io_Bus,
    input  logic                  i_Wr_En,
    input  logic [2:0]            i_Wr_Addr,
    input  logic [7:0]            i_Wr_Data,
    input  logic [2:0]            i_Rd_Addr,
    output logic [7:0]            o_Rd_Data,
    output logic [2:0]            o_Banderas,
    output logic                  o_Done,
    output logic                  o_Busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_WRITE
    } state_t;

    localparam logic [3:0] C_WAIT_INIT = 4'(ALU_WAIT - 1);

    state_t      r_State;
    logic [3:0]  r_Control;
    logic [2:0]  r_Rd;
    logic [2:0]  r_Rs1;
    logic [2:0]  r_Rs2;
    logic [3:0]  r_Cnt;
    logic        r_Done;
    logic        r_Busy;
    logic [2:0]  r_Banderas;
    logic [7:0]  r_Regs [8];

    logic        w_ExtWrOk;
    logic        w_WbOk;
    logic [7:0]  w_Op1;
    logic [7:0]  w_Op2;

`ifdef SECALU_R0_CERO_EN
    assign w_ExtWrOk = i_Wr_En && (i_Wr_Addr != 3'd0);
    assign w_WbOk    = r_Control[3] && (r_Rd != 3'd0);
`else
    assign w_ExtWrOk = i_Wr_En;
    assign w_WbOk    = r_Control[3];
`endif

    assign w_Op1 = r_Regs[r_Rs1];
    assign w_Op2 = r_Regs[r_Rs2];

    assign io_Bus.o_Operandos   = {w_Op2, w_Op1};
    assign io_Bus.o_Control_ALU = r_Control;
    assign io_Bus.o_Instr_Ready = ~r_Busy;
    assign o_Rd_Data            = r_Regs[i_Rd_Addr];
    assign o_Banderas           = r_Banderas;
    assign o_Done               = r_Done;
    assign o_Busy               = r_Busy;

    // Sequencer FSM, register file and flag latch, all with synchronous active-low reset
    always_ff @(posedge i_Clk) begin
        if (!i_Reset_n) begin
            r_State    <= S_IDLE;
            r_Control  <= 4'b0000;
            r_Rd       <= 3'd0;
            r_Rs1      <= 3'd0;
            r_Rs2      <= 3'd0;
            r_Cnt      <= 4'd0;
            r_Done     <= 1'b0;
            r_Busy     <= 1'b0;
            r_Banderas <= 3'b000;
            for (int i = 0; i < 8; i++) begin
                r_Regs[i] <= 8'h00;
            end
        end else begin
            r_Done <= 1'b0;
            case (r_State)
                S_IDLE: begin
                    if (w_ExtWrOk) begin
                        r_Regs[i_Wr_Addr] <= i_Wr_Data;
                    end
                    if (io_Bus.i_Instr_Valid) begin
                        r_Control <= io_Bus.i_Instr[12:9];
                        r_Rd      <= io_Bus.i_Instr[8:6];
                        r_Rs1     <= io_Bus.i_Instr[5:3];
                        r_Rs2     <= io_Bus.i_Instr[2:0];
                        r_Busy    <= 1'b1;
                        r_State   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_Cnt   <= C_WAIT_INIT;
                    r_State <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_Cnt == 4'd0) begin
                        r_Done  <= 1'b1;
                        r_State <= S_WRITE;
                    end else begin
                        r_Cnt <= r_Cnt - 4'd1;
                    end
                end
                S_WRITE: begin
                    if (w_WbOk) begin
                        r_Regs[r_Rd] <= io_Bus.i_Resultado;
                    end
                    if (r_Control[3]) begin
                        r_Banderas <= io_Bus.i_Banderas;
                    end
                    r_Control <= 4'b0000;
                    r_Busy    <= 1'b0;
                    r_State   <= S_IDLE;
                end
                default: begin
                    r_State <= S_IDLE;
                end
            endcase
        end
    end

endmodule
